// File: rtl/gray_decoder.sv
// Gray-count receiver: SYNC_STAGES synchroniser, decode to binary, step/direction/error flags; gray_in to bin_out in SYNC_STAGES+1 clocks.
// No backpressure (enable only gates acceptance); GRAY_DEC_ERR_CNT_EN builds the saturating err_count, otherwise it reads 0.
module gray_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             moved,
  output logic             dir_up,
  output logic             step_err,
  output logic [7:0]       err_count
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] g_prev;
  logic [WIDTH-1:0] b_dec;
  logic [WIDTH-1:0] diff;
  logic             primed;
  logic             single_step;
  logic             multi_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g_s = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign b_dec[i] = ^g_s[WIDTH-1:i];
  end

  // Clearing the lowest set bit leaves something only when two or more bits differ.
  assign diff        = g_s ^ g_prev;
  assign multi_step  = |(diff & (diff - WIDTH'(1)));
  assign single_step = (diff != '0) && !multi_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_out  <= '0;
      g_prev   <= '0;
      valid    <= 1'b0;
      moved    <= 1'b0;
      dir_up   <= 1'b0;
      step_err <= 1'b0;
      primed   <= 1'b0;
    end else begin
      moved    <= 1'b0;
      step_err <= 1'b0;
      if (enable) begin
        bin_out <= b_dec;
        g_prev  <= g_s;
        valid   <= 1'b1;
        primed  <= 1'b1;
        if (primed) begin
          if (single_step) begin
            moved  <= 1'b1;
            dir_up <= (b_dec == bin_out + WIDTH'(1));
          end else if (multi_step) begin
            step_err <= 1'b1;
          end
        end
      end else begin
        primed <= 1'b0;
      end
    end
  end

`ifdef GRAY_DEC_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= 8'd0;
    end else if (enable && primed && multi_step && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_gray_decoder.sv
// Scoreboarded bench for gray_decoder: expectations queued at drive time, popped at the observation edge.
module tb_gray_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] gray_in;
  logic [7:0] bin_out;
  logic       valid, moved, dir_up, step_err;
  logic [7:0] err_count;

  typedef struct packed {
    logic       vld;
    logic       mv;
    logic       up;
    logic       err;
    logic [7:0] bin;
    logic [7:0] ec;
  } obs_t;

  obs_t exp_q[$];
  obs_t e, o;
  int   total = 0;
  int   bad   = 0;

  gray_decoder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .gray_in(gray_in),
    .bin_out(bin_out), .valid(valid), .moved(moved), .dir_up(dir_up),
    .step_err(step_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ec_model(input int n);
`ifdef GRAY_DEC_ERR_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return (n < 0) ? 8'd1 : 8'd0;
`endif
  endfunction

  function automatic obs_t mk(input logic v, input logic m, input logic u, input logic er,
                              input logic [7:0] b, input int n);
    obs_t r;
    r.vld = v; r.mv = m; r.up = u; r.err = er; r.bin = b; r.ec = ec_model(n);
    return r;
  endfunction

  function automatic obs_t observe();
    obs_t r;
    r.vld = valid; r.mv = moved; r.up = dir_up; r.err = step_err; r.bin = bin_out; r.ec = err_count;
    return r;
  endfunction

  // Park on a new Gray value with enable low so the next accepted sample is unchecked.
  task automatic reposition(input logic [7:0] g);
    enable  = 1'b0;
    gray_in = g;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; gray_in = 8'h5A;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(mk(0, 0, 0, 0, 8'h00, 0));
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL reset[%0d] got=%h exp=%h", k, o, e); end
      gray_in = gray_in ^ 8'hFF;
    end
    gray_in = 8'h00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_count_up();
    logic [7:0] gs [4];
    logic [7:0] prev_bin;
    gs[0] = 8'h00; gs[1] = 8'h01; gs[2] = 8'h03; gs[3] = 8'h02;
    prev_bin = 8'h00;
    for (int k = 0; k < 4; k++) begin
      gray_in = gs[k];
      exp_q.push_back(mk(1, (k != 0), (k != 0), 0, 8'(k), 0));
      exp_q.push_back(mk(1, 0, (k != 0), 0, 8'(k), 0));
      repeat (2) @(negedge clk);
      total++;
      if (bin_out !== prev_bin) begin bad++; $display("FAIL count_latency[%0d] got=%h exp=%h", k, bin_out, prev_bin); end
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL count_step[%0d] got=%h exp=%h", k, o, e); end
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL count_hold[%0d] got=%h exp=%h", k, o, e); end
      prev_bin = 8'(k);
    end
  endtask

  task automatic test_wrap();
    exp_q.push_back(mk(1, 0, 1, 0, 8'hFF, 0));
    reposition(8'h80);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL wrap_start got=%h exp=%h", o, e); end

    gray_in = 8'h00;
    exp_q.push_back(mk(1, 1, 1, 0, 8'h00, 0));
    repeat (3) @(negedge clk);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL wrap_up got=%h exp=%h", o, e); end
    @(negedge clk);

    gray_in = 8'h80;
    exp_q.push_back(mk(1, 1, 0, 0, 8'hFF, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 8'hFF, 0));
    repeat (3) @(negedge clk);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL wrap_down got=%h exp=%h", o, e); end
    @(negedge clk);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL wrap_down_hold got=%h exp=%h", o, e); end
  endtask

  task automatic test_illegal_jump();
    exp_q.push_back(mk(1, 0, 0, 0, 8'h01, 0));
    reposition(8'h01);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL jump_start got=%h exp=%h", o, e); end

    gray_in = 8'h02;
    exp_q.push_back(mk(1, 0, 0, 1, 8'h03, 1));
    exp_q.push_back(mk(1, 0, 0, 0, 8'h03, 1));
    repeat (3) @(negedge clk);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL jump_err got=%h exp=%h", o, e); end
    @(negedge clk);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL jump_pulse_end got=%h exp=%h", o, e); end
  endtask

  task automatic test_saturation();
    gray_in = 8'h00;
    exp_q.push_back(mk(1, 0, 0, 0, 8'h00, 1));
    repeat (4) @(negedge clk);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL sat_start got=%h exp=%h", o, e); end

    for (int i = 0; i < 100; i++) begin
      gray_in = (i % 2 == 0) ? 8'h03 : 8'h00;
      repeat (2) @(negedge clk);
    end
    exp_q.push_back(mk(1, 0, 0, 0, 8'h00, 101));
    repeat (4) @(negedge clk);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL sat_mid got=%h exp=%h", o, e); end

    for (int i = 100; i < 300; i++) begin
      gray_in = (i % 2 == 0) ? 8'h03 : 8'h00;
      repeat (2) @(negedge clk);
    end
    exp_q.push_back(mk(1, 0, 0, 0, 8'h00, 301));
    repeat (4) @(negedge clk);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL sat_end got=%h exp=%h", o, e); end
  endtask

  task automatic test_enable_gap();
    enable  = 1'b0;
    gray_in = 8'h0F;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(mk(1, 0, 0, 0, 8'h00, 301));
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL gap_hold[%0d] got=%h exp=%h", k, o, e); end
    end
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(1, 0, 0, 0, 8'h0A, 301));
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL gap_resume[%0d] got=%h exp=%h", k, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    gray_in = 8'h0E;
    exp_q.push_back(mk(1, 1, 1, 0, 8'h0B, 301));
    exp_q.push_back(mk(0, 0, 0, 0, 8'h00, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 8'h00, 0));
    repeat (3) @(negedge clk);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL mid_pre got=%h exp=%h", o, e); end
    #1 rst = 1'b0;
    #1;
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL mid_async got=%h exp=%h", o, e); end
    @(negedge clk);
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL mid_held got=%h exp=%h", o, e); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; gray_in = 8'h00;
    test_reset();
    test_count_up();
    test_wrap();
    test_illegal_jump();
    test_saturation();
    test_enable_gap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
